// File: rtl/mdio_access_scheduler.sv
// Serialises two register requesters and a periodic link-status poll onto one
// MDIO engine; exactly one engine transaction is in flight at any time.
module mdio_access_scheduler #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [4:0]  STATUS_REG  = 5'd1,
  parameter logic [15:0] POLL_PERIOD = 16'd50000,
  parameter logic [15:0] TIMEOUT     = 16'd4096
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rw,
  input  logic [4:0]  req_reg0,
  input  logic [4:0]  req_reg1,
  input  logic [15:0] req_wdata0,
  input  logic [15:0] req_wdata1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        eng_start,
  output logic        eng_rw,
  output logic [4:0]  eng_phy_addr,
  output logic [4:0]  eng_reg_addr,
  output logic [15:0] eng_wdata,
  input  logic        eng_done,
  input  logic [15:0] eng_rdata,
  output logic        link_up,
  output logic        irq_link_down,
  input  logic        irq_clear
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] POLL_LAST = POLL_PERIOD - 16'd1;
  localparam logic [15:0] WAIT_LAST = TIMEOUT - 16'd1;

  state_t      state;
  state_t      state_next;
  logic        ptr;
  logic [15:0] poll_cnt;
  logic        poll_pend;
  logic [15:0] wait_cnt;
  logic        cmd_rw;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        own_poll;
  logic        own_idx;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        link_q;
  logic        irq_q;

  logic        poll_wrap;
  logic        poll_req;
  logic        grant_poll;
  logic        grant_req;
  logic        grant_idx;
  logic        wait_ok;
  logic        wait_tmo;
  logic        poll_ok;
  logic        link_fall;

  // A wrap competes in the same cycle it happens, so a coincident request loses.
  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign poll_req  = poll_pend | poll_wrap;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_poll = 1'b0;
    grant_req  = 1'b0;
    grant_idx  = 1'b0;
    wait_ok    = 1'b0;
    wait_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (poll_req) begin
            grant_poll = 1'b1;
            state_next = ISSUE;
          end else if (req_valid != 2'b00) begin
            grant_req  = 1'b1;
            grant_idx  = (req_valid == 2'b11) ? ~ptr : req_valid[1];
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          wait_ok    = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_tmo   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b1;
      poll_cnt  <= 16'd0;
      poll_pend <= 1'b0;
      wait_cnt  <= 16'd0;
      cmd_rw    <= 1'b0;
      cmd_reg   <= 5'd0;
      cmd_wdata <= 16'd0;
      own_poll  <= 1'b0;
      own_idx   <= 1'b0;
      rdata_q   <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      poll_cnt  <= poll_wrap ? 16'd0 : poll_cnt + 16'd1;
      poll_pend <= poll_req & ~grant_poll;

      if (grant_poll) begin
        cmd_rw    <= 1'b1;
        cmd_reg   <= STATUS_REG;
        cmd_wdata <= 16'd0;
        own_poll  <= 1'b1;
      end else if (grant_req) begin
        cmd_rw    <= req_rw[grant_idx];
        cmd_reg   <= grant_idx ? req_reg1 : req_reg0;
        cmd_wdata <= grant_idx ? req_wdata1 : req_wdata0;
        own_poll  <= 1'b0;
        own_idx   <= grant_idx;
        ptr       <= grant_idx;
      end

      if (state == ISSUE) begin
        wait_cnt <= 16'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      // Writes return zero data so rsp_rdata never leaks a stale read.
      if (wait_ok) begin
        rdata_q <= cmd_rw ? eng_rdata : 16'd0;
        err_q   <= 1'b0;
      end else if (wait_tmo) begin
        rdata_q <= 16'd0;
        err_q   <= 1'b1;
      end
    end
  end

  assign poll_ok   = (state == RESP) && own_poll && !err_q;
  assign link_fall = poll_ok && link_q && !rdata_q[2];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      link_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (poll_ok) begin
        link_q <= rdata_q[2];
      end
      if (link_fall) begin
        irq_q <= 1'b1;
      end else if (irq_clear) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign req_ready     = grant_req ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid     = ((state == RESP) && !own_poll) ? (own_idx ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign eng_start     = (state == ISSUE);
  assign eng_rw        = cmd_rw;
  assign eng_phy_addr  = PHY_ADDR;
  assign eng_reg_addr  = cmd_reg;
  assign eng_wdata     = cmd_wdata;
  assign link_up       = link_q;
  assign irq_link_down = irq_q;

endmodule

// File: tb/tb_mdio_access_scheduler.sv
// Directed bench: instance a (default poll/timeout) for request traffic and
// reset, instance b (fast poll, short timeout) for polling and timeout cases.
module tb_mdio_access_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic        a_rst, a_eng_done, a_irq_clear;
  logic [1:0]  a_req_valid, a_req_rw, a_req_ready, a_rsp_valid;
  logic [4:0]  a_req_reg0, a_req_reg1, a_eng_phy_addr, a_eng_reg_addr;
  logic [15:0] a_req_wdata0, a_req_wdata1, a_rsp_rdata, a_eng_wdata, a_eng_rdata;
  logic        a_rsp_err, a_eng_start, a_eng_rw, a_link_up, a_irq_link_down;

  logic        b_rst, b_eng_done, b_irq_clear;
  logic [1:0]  b_req_valid, b_req_rw, b_req_ready, b_rsp_valid;
  logic [4:0]  b_req_reg0, b_req_reg1, b_eng_phy_addr, b_eng_reg_addr;
  logic [15:0] b_req_wdata0, b_req_wdata1, b_rsp_rdata, b_eng_wdata, b_eng_rdata;
  logic        b_rsp_err, b_eng_start, b_eng_rw, b_link_up, b_irq_link_down;

  mdio_access_scheduler u_a (
    .clk_in(clk), .reset(a_rst),
    .req_valid(a_req_valid), .req_rw(a_req_rw),
    .req_reg0(a_req_reg0), .req_reg1(a_req_reg1),
    .req_wdata0(a_req_wdata0), .req_wdata1(a_req_wdata1),
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .eng_start(a_eng_start), .eng_rw(a_eng_rw),
    .eng_phy_addr(a_eng_phy_addr), .eng_reg_addr(a_eng_reg_addr),
    .eng_wdata(a_eng_wdata), .eng_done(a_eng_done), .eng_rdata(a_eng_rdata),
    .link_up(a_link_up), .irq_link_down(a_irq_link_down), .irq_clear(a_irq_clear)
  );

  mdio_access_scheduler #(
    .PHY_ADDR(5'd7), .STATUS_REG(5'd1), .POLL_PERIOD(16'd100), .TIMEOUT(16'd16)
  ) u_b (
    .clk_in(clk), .reset(b_rst),
    .req_valid(b_req_valid), .req_rw(b_req_rw),
    .req_reg0(b_req_reg0), .req_reg1(b_req_reg1),
    .req_wdata0(b_req_wdata0), .req_wdata1(b_req_wdata1),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .eng_start(b_eng_start), .eng_rw(b_eng_rw),
    .eng_phy_addr(b_eng_phy_addr), .eng_reg_addr(b_eng_reg_addr),
    .eng_wdata(b_eng_wdata), .eng_done(b_eng_done), .eng_rdata(b_eng_rdata),
    .link_up(b_link_up), .irq_link_down(b_irq_link_down), .irq_clear(b_irq_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic run_to(input int k);
    while (cyc < base + k) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit early;
    a_rst = 1'b1; a_req_valid = 2'b00; a_req_rw = 2'b00;
    a_req_reg0 = 5'd0; a_req_reg1 = 5'd0; a_req_wdata0 = 16'd0; a_req_wdata1 = 16'd0;
    a_eng_done = 1'b0; a_eng_rdata = 16'd0; a_irq_clear = 1'b0;
    b_rst = 1'b1; b_req_valid = 2'b00; b_req_rw = 2'b00;
    b_req_reg0 = 5'd0; b_req_reg1 = 5'd0; b_req_wdata0 = 16'd0; b_req_wdata1 = 16'd0;
    b_eng_done = 1'b0; b_eng_rdata = 16'd0; b_irq_clear = 1'b0;

    // Reset values, with a request pending that must not be accepted
    step(); step();
    a_req_valid = 2'b01;
    settle();
    chk("rst_ready", a_req_ready, 2'b00);
    chk("rst_rspv", a_rsp_valid, 2'b00);
    chk("rst_start", a_eng_start, 1'b0);
    chk("rst_phy", a_eng_phy_addr, 5'd1);
    chk("rst_reg", a_eng_reg_addr, 5'd0);
    chk("rst_rw", a_eng_rw, 1'b0);
    chk("rst_wdata", a_eng_wdata, 16'h0000);
    chk("rst_rdata", a_rsp_rdata, 16'h0000);
    chk("rst_err", a_rsp_err, 1'b0);
    chk("rst_link", a_link_up, 1'b0);
    chk("rst_irq", a_irq_link_down, 1'b0);
    a_req_valid = 2'b00;
    step();
    a_rst = 1'b0;

    // Contention: both held, writes; grants alternate starting with 0
    a_req_valid = 2'b11; a_req_rw = 2'b00;
    a_req_reg0 = 5'd5; a_req_reg1 = 5'd9;
    a_req_wdata0 = 16'h1111; a_req_wdata1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("cont_ready", a_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("cont_start", a_eng_start, 1'b1);
      chk("cont_reg", a_eng_reg_addr, (i % 2 == 0) ? 5'd5 : 5'd9);
      chk("cont_wdata", a_eng_wdata, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      step();
      a_eng_done = 1'b1; a_eng_rdata = 16'h3C3C;
      step();
      a_eng_done = 1'b0;
      settle();
      chk("cont_rspv", a_rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_wr_rdata", a_rsp_rdata, 16'h0000);
      step();
    end
    a_req_valid = 2'b00;

    // Single read of reg 3, done after 40 WAIT cycles; requester 1 withdraws meanwhile
    a_req_valid = 2'b01; a_req_rw = 2'b01; a_req_reg0 = 5'd3;
    settle();
    chk("rd_ready", a_req_ready, 2'b01);
    chk("rd_nostart", a_eng_start, 1'b0);
    step();
    a_req_valid = 2'b00;
    settle();
    chk("rd_start", a_eng_start, 1'b1);
    chk("rd_reg", a_eng_reg_addr, 5'd3);
    chk("rd_rw", a_eng_rw, 1'b1);
    chk("rd_ready_off", a_req_ready, 2'b00);
    step();
    chk("rd_start_off", a_eng_start, 1'b0);
    a_req_valid = 2'b10; a_req_reg1 = 5'd17;
    early = 1'b0;
    for (int i = 0; i < 39; i++) begin
      if (i == 10) a_req_valid = 2'b00;
      step();
      if (a_rsp_valid != 2'b00 || a_eng_reg_addr != 5'd3) early = 1'b1;
    end
    chk("rd_wait_stable", early, 1'b0);
    a_eng_done = 1'b1; a_eng_rdata = 16'hA5A5;
    settle();
    chk("rd_rspv_pre", a_rsp_valid, 2'b00);
    step();
    a_eng_done = 1'b0;
    settle();
    chk("rd_rspv", a_rsp_valid, 2'b01);
    chk("rd_rdata", a_rsp_rdata, 16'hA5A5);
    chk("rd_err", a_rsp_err, 1'b0);
    step();
    chk("withdraw_ready", a_req_ready, 2'b00);
    chk("rd_rspv_off", a_rsp_valid, 2'b00);

    // Stray eng_done while idle
    a_eng_done = 1'b1; a_eng_rdata = 16'hFFFF;
    step();
    a_eng_done = 1'b0;
    settle();
    chk("stray_rspv", a_rsp_valid, 2'b00);
    chk("stray_start", a_eng_start, 1'b0);
    chk("stray_rdata", a_rsp_rdata, 16'hA5A5);

    // Reset asserted in WAIT, then a normal write
    a_req_valid = 2'b10; a_req_rw = 2'b10; a_req_reg1 = 5'd12; a_req_wdata1 = 16'hBEEF;
    settle();
    chk("rw_ready", a_req_ready, 2'b10);
    step();
    a_req_valid = 2'b00;
    step(); step();
    a_rst = 1'b1;
    settle();
    chk("rw_rst_reg", a_eng_reg_addr, 5'd0);
    chk("rw_rst_wdata", a_eng_wdata, 16'h0000);
    chk("rw_rst_rw", a_eng_rw, 1'b0);
    chk("rw_rst_start", a_eng_start, 1'b0);
    a_eng_done = 1'b1; a_eng_rdata = 16'h7777;
    step();
    a_eng_done = 1'b0;
    chk("rw_rst_rspv", a_rsp_valid, 2'b00);
    a_rst = 1'b0;
    step();
    chk("rw_after_rspv", a_rsp_valid, 2'b00);
    a_req_valid = 2'b01; a_req_rw = 2'b00; a_req_reg0 = 5'd4; a_req_wdata0 = 16'h1234;
    settle();
    chk("post_ready", a_req_ready, 2'b01);
    step();
    a_req_valid = 2'b00;
    settle();
    chk("post_start", a_eng_start, 1'b1);
    chk("post_wdata", a_eng_wdata, 16'h1234);
    chk("post_reg", a_eng_reg_addr, 5'd4);
    step(); step(); step();
    a_eng_done = 1'b1; a_eng_rdata = 16'h5555;
    step();
    a_eng_done = 1'b0;
    settle();
    chk("post_rspv", a_rsp_valid, 2'b01);
    chk("post_rdata", a_rsp_rdata, 16'h0000);
    chk("post_err", a_rsp_err, 1'b0);

    // Instance b: link polling every 100 cycles
    step();
    chk("b_rst_phy", b_eng_phy_addr, 5'd7);
    chk("b_rst_link", b_link_up, 1'b0);
    b_rst = 1'b0;
    base = cyc;
    run_to(99);
    chk("p1_pre", b_eng_start, 1'b0);
    run_to(100);
    chk("p1_start", b_eng_start, 1'b1);
    chk("p1_reg", b_eng_reg_addr, 5'd1);
    chk("p1_phy", b_eng_phy_addr, 5'd7);
    chk("p1_rw", b_eng_rw, 1'b1);
    chk("p1_ready", b_req_ready, 2'b00);
    run_to(101); b_eng_done = 1'b1; b_eng_rdata = 16'h0004;
    run_to(102); b_eng_done = 1'b0;
    settle();
    chk("p1_rspv", b_rsp_valid, 2'b00);
    chk("p1_link_pre", b_link_up, 1'b0);
    run_to(103);
    chk("p1_link", b_link_up, 1'b1);
    chk("p1_irq", b_irq_link_down, 1'b0);
    run_to(200);
    chk("p2_start", b_eng_start, 1'b1);
    run_to(201); b_eng_done = 1'b1; b_eng_rdata = 16'h0000;
    run_to(202); b_eng_done = 1'b0;
    run_to(203);
    chk("p2_link", b_link_up, 1'b0);
    chk("p2_irq", b_irq_link_down, 1'b1);
    run_to(210);
    chk("p2_irq_hold", b_irq_link_down, 1'b1);
    b_irq_clear = 1'b1;
    run_to(211); b_irq_clear = 1'b0;
    settle();
    chk("p2_irq_clr", b_irq_link_down, 1'b0);
    run_to(301); b_eng_done = 1'b1; b_eng_rdata = 16'h0004;
    run_to(302); b_eng_done = 1'b0;
    run_to(303);
    chk("p3_link", b_link_up, 1'b1);
    run_to(401); b_eng_done = 1'b1; b_eng_rdata = 16'h0000;
    run_to(402); b_eng_done = 1'b0; b_irq_clear = 1'b1;
    run_to(403); b_irq_clear = 1'b0;
    settle();
    chk("p4_set_wins", b_irq_link_down, 1'b1);
    chk("p4_link", b_link_up, 1'b0);
    run_to(410); b_irq_clear = 1'b1;
    run_to(411); b_irq_clear = 1'b0;

    // Poll wrap coincides with requester 1; then requester 1 times out
    run_to(499);
    b_req_valid = 2'b10; b_req_rw = 2'b10; b_req_reg1 = 5'd20;
    settle();
    chk("pv_ready_poll", b_req_ready, 2'b00);
    run_to(500);
    chk("pv_start", b_eng_start, 1'b1);
    chk("pv_reg", b_eng_reg_addr, 5'd1);
    run_to(501); b_eng_done = 1'b1; b_eng_rdata = 16'h0004;
    run_to(502); b_eng_done = 1'b0;
    settle();
    chk("pv_rspv", b_rsp_valid, 2'b00);
    chk("pv_ready_resp", b_req_ready, 2'b00);
    run_to(503);
    chk("pv_ready_r1", b_req_ready, 2'b10);
    chk("pv_link", b_link_up, 1'b1);
    run_to(504); b_req_valid = 2'b00;
    settle();
    chk("to_start", b_eng_start, 1'b1);
    chk("to_reg", b_eng_reg_addr, 5'd20);
    run_to(520);
    chk("to_rspv_pre", b_rsp_valid, 2'b00);
    run_to(521);
    chk("to_rspv", b_rsp_valid, 2'b10);
    chk("to_err", b_rsp_err, 1'b1);
    chk("to_rdata", b_rsp_rdata, 16'h0000);
    run_to(522); b_eng_done = 1'b1; b_eng_rdata = 16'hFFFF;
    run_to(523); b_eng_done = 1'b0;
    settle();
    chk("late_rspv", b_rsp_valid, 2'b00);
    chk("late_start", b_eng_start, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_access_scheduler.md
MDIO_ACCESS_SCHEDULER -- requirements
Module: mdio_access_scheduler

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PHY_ADDR, 5'd1, PHY address driven on every engine command.
- STATUS_REG, 5'd1, PHY register read by the internal link poller.
- POLL_PERIOD, 16'd50000, clk_in cycles between link polls.
- TIMEOUT, 16'd4096, max clk_in cycles from eng_start to eng_done.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk_in, input, 1, single clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- req_valid, input, 2, per-requester request level, held until accepted.
- req_rw, input, 2, per-requester op: 1 = read, 0 = write.
- req_reg0 / req_reg1, input, 5 each, register address for requester 0 / 1.
- req_wdata0 / req_wdata1, input, 16 each, write data for requester 0 / 1.
- req_ready, output, 2, one-cycle accept pulse per requester.
- rsp_valid, output, 2, one-cycle completion pulse per requester.
- rsp_rdata, output, 16, shared read data; valid while any rsp_valid bit is high.
- rsp_err, output, 1, timeout flag; qualified by rsp_valid.
- eng_start, output, 1, one-cycle command pulse to the MDIO engine.
- eng_rw, output, 1, command op.
- eng_phy_addr, output, 5, command PHY address.
- eng_reg_addr, output, 5, command register address.
- eng_wdata, output, 16, command write data.
- eng_done, input, 1, engine completion pulse.
- eng_rdata, input, 16, engine read data; valid with eng_done.
- link_up, output, 1, bit 2 of the last successful status poll.
- irq_link_down, output, 1, sticky; set on a link_up 1->0 transition.
- irq_clear, input, 1, clears irq_link_down.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and SHALL hold exactly one engine transaction outstanding at any time.
REQ-004 A free-running 16-bit poll counter SHALL count 0 to POLL_PERIOD-1, wrap to 0, and set poll_pend at the wrap.
REQ-005 poll_pend SHALL clear when the poll is granted and SHALL NOT accumulate; a wrap while poll_pend is already set is dropped.
REQ-006 IDLE arbitration SHALL use this order:
- poll_pend has highest priority.
- Between requesters 0 and 1, round-robin on a last-grant pointer; the pointer resets to 1, so requester 0 wins the first contention.
REQ-007 On a grant, the FSM SHALL go to ISSUE in the same cycle:
- Latch the command (rw, register address, wdata, owner).
- Pulse req_ready[owner]; no req_ready pulse for a poll grant.
- Update the pointer only on requester grants.
REQ-008 ISSUE SHALL last exactly one cycle, pulse eng_start with the eng_* fields stable, and go to WAIT; eng_* fields SHALL stay stable until RESP.
REQ-009 A poll command SHALL be a read of STATUS_REG at PHY_ADDR.
REQ-010 WAIT SHALL count cycles from 0:
- On eng_done, latch eng_rdata and go to RESP.
- If the count reaches TIMEOUT-1 without eng_done, go to RESP with an error.
- eng_done and the timeout in the same cycle count as success.
REQ-011 RESP SHALL last one cycle:
- For a requester owner, pulse rsp_valid[owner], drive rsp_rdata (write ops: 16'h0000) and rsp_err.
- For the poll owner, update link_up from rdata[2] only on success; no rsp_valid pulse.
- Return to IDLE.
REQ-012 Grant-to-eng_start latency SHALL be 1 cycle; eng_done-to-rsp_valid latency SHALL be 1 cycle; a new grant SHALL be possible in the cycle after RESP.
REQ-013 irq_link_down SHALL set on the cycle link_up goes 1->0 and clear on irq_clear. When set and clear coincide, set SHALL win.
REQ-014 eng_done received outside WAIT SHALL be ignored.
REQ-015 req_valid dropped before acceptance SHALL withdraw the request with no side effects.

Reset
REQ-016 Asserting reset at any time, including mid-transaction, SHALL asynchronously force the following; no rsp_valid pulse is emitted for an aborted transaction:
- FSM to IDLE.
- All counters and poll_pend to 0.
- Pointer to 1.
- req_ready, rsp_valid, rsp_err and eng_start to 0.
- rsp_rdata, eng_wdata, eng_reg_addr and eng_rw to 0.
- eng_phy_addr to PHY_ADDR.
- link_up and irq_link_down to 0.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- Single read: req_valid=2'b01, req_rw[0]=1, req_reg0=5'd3, eng_done with eng_rdata=16'hA5A5 after 40 cycles -> req_ready[0] at grant, eng_start next cycle with reg 3, rsp_valid[0] one cycle after done, rsp_rdata=16'hA5A5, rsp_err=0.
- Contention: both requesters held valid continuously -> grants alternate 0,1,0,1; no back-to-back grant to the same requester.
- Poll: POLL_PERIOD=100, eng_rdata=16'h0004, then 16'h0000 -> link_up=1, then link_up=0 and irq_link_down=1 until irq_clear.
- Poll vs request: poll wrap and req_valid[1] in the same cycle -> poll granted first; requester 1 granted the cycle after the poll's RESP.
- Timeout: TIMEOUT=16, no eng_done -> rsp_valid with rsp_err=1 after 16 WAIT cycles; a late eng_done is ignored.
- Reset in WAIT -> all outputs at reset values immediately; no rsp_valid; the next request proceeds normally.
